// File: rtl/toggle_pattern_checker.sv
// Receive-side checker for the toggle pattern generator: tracks the expected bus value and accumulates mismatch status.
// Optional build macro TOGGLE_CHK_RESYNC_EN: realigns to a whole-bus phase slip seen in RUN.
module toggle_pattern_checker #(
    parameter int WIDTH     = 8,
    parameter int LEAD      = 5,
    parameter int PERIOD    = 4,
    parameter int ERR_CNT_W = 8,
    parameter int TGL_CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [WIDTH-1:0]     DIN,
    input  logic                 CLR_ERR,
    output logic                 ACTIVE,
    output logic                 ERR_FLAG,
    output logic [WIDTH-1:0]     ERR_MASK,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [TGL_CNT_W-1:0] TGL_CNT
);

    localparam int MAX_LP = (LEAD > PERIOD) ? LEAD : PERIOD;
    localparam int CNT_W  = (MAX_LP > 2) ? $clog2(MAX_LP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RUN} state_t;

    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic [WIDTH-1:0]       exp_q, exp_n;
    logic [TGL_CNT_W-1:0]   tgl_q, tgl_n;
    logic                   err_flag_q, err_flag_n;
    logic [WIDTH-1:0]       err_mask_q, err_mask_n;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_n;
    logic [WIDTH-1:0]       diff;
    logic                   mismatch;

    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    function automatic logic [TGL_CNT_W-1:0] tgl_sat_inc(input logic [TGL_CNT_W-1:0] v);
        return (&v) ? v : v + TGL_CNT_W'(1);
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            exp_q      <= '0;
            tgl_q      <= '0;
            err_flag_q <= 1'b0;
            err_mask_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            exp_q      <= exp_n;
            tgl_q      <= tgl_n;
            err_flag_q <= err_flag_n;
            err_mask_q <= err_mask_n;
            err_cnt_q  <= err_cnt_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        exp_n      = exp_q;
        tgl_n      = tgl_q;
        err_flag_n = err_flag_q;
        err_mask_n = err_mask_q;
        err_cnt_n  = err_cnt_q;
        diff       = DIN ^ exp_q;
        // The seed edge and disabled edges never compare.
        mismatch   = EN && (state_q != S_IDLE) && (diff != '0);

        if (!EN) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    exp_n   = DIN;
                    cnt_n   = CNT_W'(1);
                    tgl_n   = '0;
                    state_n = S_LEAD;
                end
                S_LEAD: begin
                    if (cnt_q == CNT_W'(LEAD - 1)) begin
                        exp_n   = ~exp_q;
                        cnt_n   = '0;
                        tgl_n   = tgl_sat_inc(tgl_q);
                        state_n = S_RUN;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_W'(PERIOD - 1)) begin
                        exp_n = ~exp_q;
                        cnt_n = '0;
                        tgl_n = tgl_sat_inc(tgl_q);
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

`ifdef TOGGLE_CHK_RESYNC_EN
        // A fully inverted bus means the generator slipped phase; adopt its timing instead of the scheduled inversion.
        if (mismatch && (state_q == S_RUN) && (DIN == ~exp_q)) begin
            exp_n = DIN;
            cnt_n = CNT_W'(1);
            tgl_n = tgl_q;
        end
`endif

        if (CLR_ERR) begin
            err_flag_n = mismatch;
            err_mask_n = mismatch ? diff : '0;
            err_cnt_n  = mismatch ? ERR_CNT_W'(1) : '0;
        end else if (mismatch) begin
            err_flag_n = 1'b1;
            err_mask_n = err_mask_q | diff;
            err_cnt_n  = err_sat_inc(err_cnt_q);
        end
    end

    assign ACTIVE   = (state_q != S_IDLE);
    assign ERR_FLAG = err_flag_q;
    assign ERR_MASK = err_mask_q;
    assign ERR_CNT  = err_cnt_q;
    assign TGL_CNT  = tgl_q;

endmodule

// File: tb/tb_toggle_pattern_checker.sv
// Directed bench for toggle_pattern_checker: generator-shaped stimulus with hand-computed status expectations.
module tb_toggle_pattern_checker;

    localparam int LEAD_T   = 5;
    localparam int PERIOD_T = 4;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic [7:0]  DIN;
    logic        CLR_ERR;
    logic        ACTIVE;
    logic        ERR_FLAG;
    logic [7:0]  ERR_MASK;
    logic [7:0]  ERR_CNT;
    logic [15:0] TGL_CNT;

    int tests = 0;
    int fails = 0;

    toggle_pattern_checker #(
        .WIDTH(8), .LEAD(LEAD_T), .PERIOD(PERIOD_T), .ERR_CNT_W(8), .TGL_CNT_W(16)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DIN(DIN), .CLR_ERR(CLR_ERR),
        .ACTIVE(ACTIVE), .ERR_FLAG(ERR_FLAG), .ERR_MASK(ERR_MASK),
        .ERR_CNT(ERR_CNT), .TGL_CNT(TGL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Generator output seen before enabled edge k (seed edge is k=1).
    function automatic logic [7:0] din_at(input logic [7:0] s, input int k);
        int n;
        if (k <= LEAD_T) return s;
        n = 1 + (k - 1 - LEAD_T) / PERIOD_T;
        return n[0] ? ~s : s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic [7:0] din, input logic clr);
        EN      = en;
        DIN     = din;
        CLR_ERR = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic gen_edges(input logic [7:0] s, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) step(1'b1, din_at(s, k), 1'b0);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; DIN = 8'h00; CLR_ERR = 1'b0;
        #1;
        chk("rst_active", ACTIVE, 0);
        chk("rst_flag", ERR_FLAG, 0);
        chk("rst_mask", ERR_MASK, 0);
        chk("rst_errcnt", ERR_CNT, 0);
        chk("rst_tglcnt", TGL_CNT, 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;

        // Clean run seeded 0x00, inversions at edges 5,9,13,17
        gen_edges(8'h00, 1, 1);
        chk("t1_seed_active", ACTIVE, 1);
        chk("t1_seed_tgl", TGL_CNT, 0);
        gen_edges(8'h00, 2, 4);
        chk("t1_pre_inv_tgl", TGL_CNT, 0);
        gen_edges(8'h00, 5, 5);
        chk("t1_first_inv_tgl", TGL_CNT, 1);
        gen_edges(8'h00, 6, 20);
        chk("t1_flag", ERR_FLAG, 0);
        chk("t1_errcnt", ERR_CNT, 0);
        chk("t1_tgl", TGL_CNT, 4);
        chk("t1_active", ACTIVE, 1);

        // Single corrupted bit while generator drives 0xFF
        gen_edges(8'h00, 21, 22);
        chk("t2_pre_flag", ERR_FLAG, 0);
        step(1'b1, 8'hFB, 1'b0);
        chk("t2_flag", ERR_FLAG, 1);
        chk("t2_mask", ERR_MASK, 8'h04);
        chk("t2_errcnt", ERR_CNT, 1);
        gen_edges(8'h00, 24, 30);
        chk("t2_errcnt_hold", ERR_CNT, 1);
        chk("t2_mask_hold", ERR_MASK, 8'h04);
        chk("t2_tgl", TGL_CNT, 7);

        // Clear on a matching edge, then drop EN while generator holds 0xFF
        step(1'b1, din_at(8'h00, 31), 1'b1);
        chk("t3_clr_flag", ERR_FLAG, 0);
        chk("t3_clr_mask", ERR_MASK, 0);
        chk("t3_clr_cnt", ERR_CNT, 0);
        step(1'b0, 8'hFF, 1'b0);
        chk("t3_active_low", ACTIVE, 0);
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        chk("t3_tgl_hold", TGL_CNT, 7);
        gen_edges(8'hFF, 1, 1);
        chk("t3_reseed_active", ACTIVE, 1);
        chk("t3_reseed_tgl", TGL_CNT, 0);
        gen_edges(8'hFF, 2, 4);
        chk("t3_pre_inv_tgl", TGL_CNT, 0);
        gen_edges(8'hFF, 5, 5);
        chk("t3_inv_tgl", TGL_CNT, 1);
        chk("t3_errcnt", ERR_CNT, 0);

        // DIN stuck at 0x00: every other block of 4 edges mismatches
        for (int k = 6; k <= 609; k++) step(1'b1, 8'h00, 1'b0);
        chk("t4_sat_cnt", ERR_CNT, 8'hFF);
        chk("t4_mask", ERR_MASK, 8'hFF);
        chk("t4_flag", ERR_FLAG, 1);
        step(1'b1, 8'h00, 1'b1);
        chk("t4_clr_new_cnt", ERR_CNT, 1);
        chk("t4_clr_new_mask", ERR_MASK, 8'hFF);
        chk("t4_clr_new_flag", ERR_FLAG, 1);

        // Async reset mid-RUN with three errors recorded
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b1);
        gen_edges(8'h00, 2, 5);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        chk("t5_pre_cnt", ERR_CNT, 3);
        chk("t5_pre_mask", ERR_MASK, 8'hFE);
        #3;
        RST = 1'b1;
        #1;
        chk("t5_async_active", ACTIVE, 0);
        chk("t5_async_flag", ERR_FLAG, 0);
        chk("t5_async_mask", ERR_MASK, 0);
        chk("t5_async_cnt", ERR_CNT, 0);
        chk("t5_async_tgl", TGL_CNT, 0);
        EN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        gen_edges(8'hAA, 1, 1);
        chk("t5_reseed_active", ACTIVE, 1);
        gen_edges(8'hAA, 2, 5);
        chk("t5_reseed_cnt", ERR_CNT, 0);
        chk("t5_reseed_tgl", TGL_CNT, 1);

        // Generator inverts one edge early in RUN
        #3;
        RST = 1'b1;
        #1;
        EN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        gen_edges(8'h00, 1, 8);
        for (int k = 9; k <= 20; k++) begin
            step(1'b1, din_at(8'h00, k + 1), 1'b0);
            if (k == 9) chk("t6_first_slip_cnt", ERR_CNT, 1);
        end
`ifdef TOGGLE_CHK_RESYNC_EN
        chk("t6_slip_cnt", ERR_CNT, 1);
`else
        chk("t6_slip_cnt", ERR_CNT, 3);
`endif
        chk("t6_slip_mask", ERR_MASK, 8'hFF);
        chk("t6_tgl", TGL_CNT, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
